rv32_fetch_buffer: RTL

- Next-generation RV32 instruction fetch stage with a parametrised prefetch queue and a pipelined memory bus using request/ready and response/valid.
- Holds up to DEPTH instructions in flight or buffered, and applies static prediction to returning instructions.
- Discards stale responses after a redirect.
- Sits between the instruction memory bus and decode; downstream stall is replaced by a valid/ready handshake.

---
 rtl/rv32_pkg.sv | 24 ++
 rtl/rv32_fetch_fifo.sv | 59 +++++
 rtl/rv32_fetch_buffer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 fetch definitions: opcode constants, immediate extraction and
// the fetch entry carried from the bus response to decode.
package rv32_pkg;

  localparam logic [6:0] RV32_OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] RV32_OPCODE_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } fetch_entry_t;

  // J-type immediate from instruction bits [31:12].
  function automatic logic [31:0] imm_j(input logic [31:12] hi);
    return {{11{hi[31]}}, hi[31], hi[19:12], hi[20], hi[30:21], 1'b0};
  endfunction

  // B-type immediate from instruction bits [31:25] and [11:7].
  function automatic logic [31:0] imm_b(input logic [31:25] hi, input logic [11:7] lo);
    return {{19{hi[31]}}, hi[31], lo[7], hi[30:25], lo[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/rv32_fetch_fifo.sv
// Synchronous fetch-entry FIFO with clear. The head is read straight from the
// storage flops, so the outputs to decode carry no combinational input path.
module rv32_fetch_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             clear,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic             full;

  assign head_valid = (count != '0);
  assign head       = mem[rd_ptr];
  assign do_pop     = pop & head_valid;
  assign full       = (count == CNT_W'(DEPTH));

  // Storage, pointers and fill count; clear discards everything buffered.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  // Overflow check: a full FIFO may only take a push alongside a pop.
  always_ff @(posedge clk) begin
    if (reset_) assert (!(push && full && !do_pop))
      else $error("fetch fifo overflow");
  end

endmodule

// File: rtl/rv32_fetch_buffer.sv
// RV32 fetch stage: credit-limited pipelined instruction reads, stale response
// discard after redirect or prediction, and a prefetch FIFO toward decode.
// Static prediction (JAL, backward branches) is built when the macro
// RV32_FETCH_PREDICT_EN is defined; otherwise fetch is purely sequential.
module rv32_fetch_buffer
  import rv32_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  localparam int         CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic        instr_read_out,
  output logic [31:0] instr_address_out,
  input  logic        instr_read_ready_in,
  input  logic        instr_read_valid_in,
  input  logic [31:0] instr_read_value_in,
  output logic        instr_valid_out,
  input  logic        instr_ready_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        branch_predicted_taken_out
);

  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic [31:0]      resp_pc_next;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_next;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   credit_used;
  logic             req_fire;
  logic             resp_fire;
  logic             live;
  logic             pred;
  fetch_entry_t     push_data;
  fetch_entry_t     head;

  assign credit_used       = {1'b0, outstanding} + {1'b0, count};
  assign instr_read_out    = (credit_used < (CNT_W + 1)'(DEPTH));
  assign instr_address_out = redirect_in ? redirect_pc_in : fetch_pc;
  assign req_fire          = instr_read_out & instr_read_ready_in;
  assign resp_fire         = instr_read_valid_in;
  assign live              = resp_fire & (discard == '0) & ~redirect_in;
  assign outstanding_next  = outstanding + CNT_W'(req_fire) - CNT_W'(resp_fire);

`ifdef RV32_FETCH_PREDICT_EN
  // Static prediction on a live response; resp_pc_next is the path after it.
  always_comb begin
    pred         = 1'b0;
    resp_pc_next = resp_pc + 32'd4;
    if (instr_read_value_in[6:0] == RV32_OPCODE_JAL) begin
      pred         = live;
      resp_pc_next = resp_pc + imm_j(instr_read_value_in[31:12]);
    end else if (instr_read_value_in[6:0] == RV32_OPCODE_BRANCH && instr_read_value_in[31]) begin
      pred         = live;
      resp_pc_next = resp_pc + imm_b(instr_read_value_in[31:25], instr_read_value_in[11:7]);
    end
  end
  assign branch_predicted_taken_out = head.pred;
`else
  logic unused_head_pred;
  assign pred                       = 1'b0;
  assign resp_pc_next               = resp_pc + 32'd4;
  assign branch_predicted_taken_out = 1'b0;
  assign unused_head_pred           = head.pred;
`endif

  assign push_data = '{instr: instr_read_value_in, pc: resp_pc, pred: pred};

  // Fetch/response PCs and in-flight bookkeeping; redirect overrides prediction.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_in) begin
        // A request fired this cycle already went to the new target.
        fetch_pc <= req_fire ? redirect_pc_in + 32'd4 : redirect_pc_in;
        resp_pc  <= redirect_pc_in;
        discard  <= outstanding_next - CNT_W'(req_fire);
      end else begin
        if (pred)          fetch_pc <= resp_pc_next;
        else if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (live)          resp_pc  <= resp_pc_next;
        // Everything still in flight after a taken prediction is sequential.
        if (pred)                            discard <= outstanding_next;
        else if (resp_fire && discard != '0) discard <= discard - CNT_W'(1);
      end
    end
  end

  // The bus may only answer reads it has accepted.
  always_ff @(posedge clk) begin
    if (reset_) assert (!(resp_fire && outstanding == '0))
      else $error("instruction response without outstanding read");
  end

  rv32_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset_     (reset_),
    .clear      (redirect_in),
    .push       (live),
    .push_data  (push_data),
    .pop        (instr_valid_out & instr_ready_in),
    .head       (head),
    .head_valid (instr_valid_out),
    .count      (count)
  );

  assign instr_out = head.instr;
  assign pc_out    = head.pc;

endmodule
